m_imem_responder: RTL and testbench

Instruction-memory responder sitting at the far end of the program counter's address bus. It accepts an 8-bit fetch address with a request strobe and returns the stored instruction word one cycle later with a valid pulse. A byte-serial program-load port fills the memory from an external loader before execution. A load FSM assembles bytes into words and auto-increments the write pointer.

---
 rtl/m_imem_responder.sv | 136 +++++++++++++
 tb/tb_m_imem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_imem_responder.sv
// ============================================================================
// Module   : m_imem_responder
// Purpose  : 256-entry instruction memory with a registered single-cycle fetch
//            port and a byte-serial program-load port.
// Options  : IMEM_PARITY_EN adds one even-parity bit per stored word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_imem_responder #(
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   w_clock,
  input  logic                   w_reset,
  input  logic [7:0]             w_bus_addr_in,
  input  logic                   w_fetch_req,
  output logic [INSTR_WIDTH-1:0] r_bus_instr_out,
  output logic                   r_instr_valid,
  input  logic                   w_load_start,
  input  logic [7:0]             w_bus_load_addr,
  input  logic [7:0]             w_bus_load_byte,
  input  logic                   w_load_byte_valid,
  input  logic                   w_load_stop,
  output logic                   r_load_ready,
  output logic [7:0]             r_bus_load_addr_out,
  output logic                   r_parity_err
);

  localparam int       c_NBYTES = INSTR_WIDTH / 8;
  localparam int       c_ASM_W  = (INSTR_WIDTH > 8) ? INSTR_WIDTH - 8 : 1;
  localparam bit [1:0] c_LAST   = 2'(c_NBYTES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_cnt;
  logic [c_ASM_W-1:0]     r_asm;
  logic [INSTR_WIDTH-1:0] r_mem [256];
  logic [INSTR_WIDTH-1:0] w_word;
  logic                   w_last;
  logic                   w_mem_we;

  // Word formed by the bytes already held plus the byte on the bus this cycle.
  generate
    if (c_NBYTES == 1) begin : g_asm_single
      assign w_word = w_bus_load_byte;
    end else begin : g_asm_multi
      assign w_word = {r_asm, w_bus_load_byte};
    end
  endgenerate

  assign w_last   = (r_cnt == c_LAST);
  assign w_mem_we = !w_reset && (r_state == S_LOAD) && !w_load_start &&
                    w_load_byte_valid && w_last;

  always_ff @(posedge w_clock) begin
    if (w_mem_we) begin
      r_mem[r_bus_load_addr_out] <= w_word;
    end
  end

`ifdef IMEM_PARITY_EN
  logic r_par [256];

  always_ff @(posedge w_clock) begin
    if (w_mem_we) begin
      r_par[r_bus_load_addr_out] <= ^w_word;
    end
  end
`endif

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      r_state             <= S_IDLE;
      r_cnt               <= 2'd0;
      r_asm               <= '0;
      r_bus_instr_out     <= '0;
      r_instr_valid       <= 1'b0;
      r_load_ready        <= 1'b0;
      r_bus_load_addr_out <= 8'd0;
      r_parity_err        <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_parity_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A load start takes priority and silently drops a same-cycle fetch.
          if (w_load_start) begin
            r_state             <= S_LOAD;
            r_load_ready        <= 1'b1;
            r_bus_load_addr_out <= w_bus_load_addr;
            r_cnt               <= 2'd0;
          end else if (w_fetch_req) begin
            r_bus_instr_out <= r_mem[w_bus_addr_in];
            r_instr_valid   <= 1'b1;
`ifdef IMEM_PARITY_EN
            r_parity_err    <= (^r_mem[w_bus_addr_in]) != r_par[w_bus_addr_in];
`endif
          end
        end
        S_LOAD: begin
          if (w_load_start) begin
            r_bus_load_addr_out <= w_bus_load_addr;
            r_cnt               <= 2'd0;
          end else begin
            if (w_load_byte_valid) begin
              r_asm <= w_word[c_ASM_W-1:0];
              if (w_last) begin
                r_bus_load_addr_out <= r_bus_load_addr_out + 8'd1;
                r_cnt               <= 2'd0;
              end else begin
                r_cnt <= r_cnt + 2'd1;
              end
            end
            // Stop discards any partial word; a completing byte was handled above.
            if (w_load_stop) begin
              r_state      <= S_IDLE;
              r_load_ready <= 1'b0;
              r_cnt        <= 2'd0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_imem_responder.sv
// ============================================================================
// Module   : tb_m_imem_responder
// Purpose  : Vector table, random traffic and parity corner checks for
//            m_imem_responder (16-bit words) against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_imem_responder;

  logic        clk = 1'b0;
  logic        rst, fetch, start, bv, stop;
  logic [7:0]  addr, laddr, lbyte;
  logic [15:0] instr;
  logic        valid, ready, perr;
  logic [7:0]  ptr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m_imem_responder #(.INSTR_WIDTH(16)) dut (
    .w_clock            (clk),
    .w_reset            (rst),
    .w_bus_addr_in      (addr),
    .w_fetch_req        (fetch),
    .r_bus_instr_out    (instr),
    .r_instr_valid      (valid),
    .w_load_start       (start),
    .w_bus_load_addr    (laddr),
    .w_bus_load_byte    (lbyte),
    .w_load_byte_valid  (bv),
    .w_load_stop        (stop),
    .r_load_ready       (ready),
    .r_bus_load_addr_out(ptr),
    .r_parity_err       (perr)
  );

  typedef struct {
    logic        rst;
    logic        fetch;
    logic [7:0]  addr;
    logic        start;
    logic [7:0]  laddr;
    logic [7:0]  lbyte;
    logic        bv;
    logic        stop;
    logic        e_valid;
    logic [15:0] e_instr;
    logic        e_ready;
    logic [7:0]  e_ptr;
  } vec_t;

  // Reference model: load mode flag, write pointer, pending-byte queue, word array.
  logic        m_load;
  logic [7:0]  m_ptr;
  logic [7:0]  m_q[$];
  logic [15:0] m_mem [256];
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_perr;
  logic        flip_on = 1'b0;
  logic [7:0]  flip_addr = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input vec_t v);
    if (v.rst) begin
      m_load = 1'b0; m_ptr = 8'd0; m_q.delete();
      m_instr = 16'd0; m_valid = 1'b0; m_perr = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
      if (!m_load) begin
        if (v.start) begin
          m_load = 1'b1; m_ptr = v.laddr; m_q.delete();
        end else if (v.fetch) begin
          m_instr = m_mem[v.addr];
          m_valid = 1'b1;
          m_perr  = flip_on && (v.addr == flip_addr);
        end
      end else if (v.start) begin
        m_ptr = v.laddr; m_q.delete();
      end else begin
        if (v.bv) begin
          m_q.push_back(v.lbyte);
          if (m_q.size() == 2) begin
            m_mem[m_ptr] = {m_q[0], m_q[1]};
            m_ptr = m_ptr + 8'd1;
            m_q.delete();
          end
        end
        if (v.stop) begin
          m_load = 1'b0; m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; fetch = v.fetch; addr = v.addr; start = v.start;
    laddr = v.laddr; lbyte = v.lbyte; bv = v.bv; stop = v.stop;
    @(posedge clk);
    model_update(v);
    #1;
    chk("model_valid", 32'(valid), 32'(m_valid));
    chk("model_ready", 32'(ready), 32'(m_load));
    chk("model_ptr",   32'(ptr),   32'(m_ptr));
    if (!$isunknown(m_instr)) begin
      chk("model_instr", 32'(instr), 32'(m_instr));
      chk("model_perr",  32'(perr),  32'(m_perr));
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic [7:0] a,
                              input logic s, input logic [7:0] la, input logic [7:0] b,
                              input logic bvl, input logic sp, input logic ev,
                              input logic [15:0] ei, input logic er, input logic [7:0] ep);
    vec_t v;
    v.rst = r; v.fetch = f; v.addr = a; v.start = s; v.laddr = la; v.lbyte = b;
    v.bv = bvl; v.stop = sp; v.e_valid = ev; v.e_instr = ei; v.e_ready = er; v.e_ptr = ep;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst = 1'b1; fetch = 1'b0; addr = 8'd0; start = 1'b0;
    laddr = 8'd0; lbyte = 8'd0; bv = 1'b0; stop = 1'b0;
    m_instr = 16'd0;

    //           rst f  addr   s  laddr  byte   bv sp  ev  instr     rdy ptr
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h10, 8'h00, 0, 0, 0, 16'h0000, 1, 8'h10));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'hAB, 1, 0, 0, 16'h0000, 1, 8'h10));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'hCD, 1, 0, 0, 16'h0000, 1, 8'h11));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h12, 1, 0, 0, 16'h0000, 1, 8'h11));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h34, 1, 0, 0, 16'h0000, 1, 8'h12));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 16'h0000, 0, 8'h12));
    tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 8'h00, 0, 0, 1, 16'hABCD, 0, 8'h12));
    tbl.push_back(mk(0, 1, 8'h11, 0, 8'h00, 8'h00, 0, 0, 1, 16'h1234, 0, 8'h12));
    tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 8'h00, 0, 0, 1, 16'hABCD, 0, 8'h12));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 16'hABCD, 0, 8'h12));
    // start beats a coincident fetch; then load wraps past 0xFF
    tbl.push_back(mk(0, 1, 8'h11, 1, 8'hFF, 8'h00, 0, 0, 0, 16'hABCD, 1, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0, 0, 16'hABCD, 1, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h02, 1, 0, 0, 16'hABCD, 1, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h03, 1, 0, 0, 16'hABCD, 1, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h04, 1, 0, 0, 16'hABCD, 1, 8'h01));
    tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 8'h00, 0, 0, 0, 16'hABCD, 1, 8'h01));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 16'hABCD, 0, 8'h01));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0102, 0, 8'h01));
    tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0304, 0, 8'h01));
    // stop with a partial word leaves the old word intact
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h10, 8'h00, 0, 0, 0, 16'h0304, 1, 8'h10));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'hEE, 1, 0, 0, 16'h0304, 1, 8'h10));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 16'h0304, 0, 8'h10));
    tbl.push_back(mk(0, 1, 8'h10, 0, 8'h00, 8'h00, 0, 0, 1, 16'hABCD, 0, 8'h10));
    // stop coincident with the final byte writes the word
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h20, 8'h00, 0, 0, 0, 16'hABCD, 1, 8'h20));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h55, 1, 0, 0, 16'hABCD, 1, 8'h20));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h66, 1, 1, 0, 16'hABCD, 0, 8'h21));
    tbl.push_back(mk(0, 1, 8'h20, 0, 8'h00, 8'h00, 0, 0, 1, 16'h5566, 0, 8'h21));
    // reset mid-load, memory survives
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h30, 8'h00, 0, 0, 0, 16'h5566, 1, 8'h30));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h77, 1, 0, 0, 16'h5566, 1, 8'h30));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0, 1, 8'h11, 0, 8'h00, 8'h00, 0, 0, 1, 16'h1234, 0, 8'h00));
    // restart inside load discards the partial word
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h40, 8'h00, 0, 0, 0, 16'h1234, 1, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h11, 1, 0, 0, 16'h1234, 1, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h50, 8'h00, 0, 0, 0, 16'h1234, 1, 8'h50));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h22, 1, 0, 0, 16'h1234, 1, 8'h50));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h33, 1, 0, 0, 16'h1234, 1, 8'h51));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 16'h1234, 0, 8'h51));
    tbl.push_back(mk(0, 1, 8'h50, 0, 8'h00, 8'h00, 0, 0, 1, 16'h2233, 0, 8'h51));

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(tbl[i].e_instr));
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_ptr",   i), 32'(ptr),   32'(tbl[i].e_ptr));
      chk($sformatf("vec%0d_perr",  i), 32'(perr),  32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      rv = mk(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0),
              8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 9) == 0), 1'b0, 16'h0, 1'b0, 8'h0);
      step(rv);
    end

    // Leave load mode cleanly before the parity corner.
    step(mk(0, 0, 8'h00, 1, 8'h60, 8'h00, 0, 0, 0, 16'h0, 0, 8'h0));
    step(mk(0, 0, 8'h00, 0, 8'h00, 8'hC3, 1, 0, 0, 16'h0, 0, 8'h0));
    step(mk(0, 0, 8'h00, 0, 8'h00, 8'h5A, 1, 1, 0, 16'h0, 0, 8'h0));
    step(mk(0, 1, 8'h60, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0, 0, 8'h0));
    chk("reload_instr", 32'(instr), 32'h0000C35A);
    chk("reload_valid", 32'(valid), 32'd1);

`ifdef IMEM_PARITY_EN
    @(negedge clk);
    dut.r_par[8'h60] = ~dut.r_par[8'h60];
    flip_on = 1'b1; flip_addr = 8'h60;
    step(mk(0, 1, 8'h60, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0, 0, 8'h0));
    chk("par_flip_err",   32'(perr),  32'd1);
    chk("par_flip_valid", 32'(valid), 32'd1);
    step(mk(0, 1, 8'h50, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0, 0, 8'h0));
    chk("par_clean_err",  32'(perr),  32'd0);
    step(mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0, 0, 8'h0));
    chk("par_idle_err",   32'(perr),  32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
